// File: rtl/reg_bank_access_ctrl.sv
// Round-robin arbiter and access sequencer for a shared clear/preset register bank.
// Optional write protection is enabled by defining REG_BANK_WPROT_EN.
module reg_bank_access_ctrl #(
    parameter int unsigned NR   = 4,
    parameter int unsigned NREG = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned DW   = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NR-1:0]      req,
    input  logic [2*NR-1:0]    req_op,
    input  logic [AW*NR-1:0]   req_addr,
    input  logic [DW*NR-1:0]   req_wdata,
    output logic [NR-1:0]      gnt,
    output logic [NR-1:0]      done,
    output logic [DW-1:0]      rdata,
    output logic               err,
    output logic [DW-1:0]      reg_d,
    output logic [NREG-1:0]    reg_we,
    output logic [NREG-1:0]    reg_clr,
    output logic [NREG-1:0]    reg_pre,
    output logic [NREG-1:0]    reg_cs,
`ifdef REG_BANK_WPROT_EN
    input  logic [NREG-1:0]    wprot,
`endif
    input  logic [DW-1:0]      reg_q
);

    localparam int unsigned RW = (NR > 1) ? $clog2(NR) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
    typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_CLEAR = 2'b10, OP_PRESET = 2'b11} op_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   rr_q, rr_d;
    logic [NR-1:0]   gnt_q, gnt_d;
    logic [NR-1:0]   done_q, done_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [DW-1:0]   reg_d_q, reg_d_d;
    logic [NREG-1:0] we_q, we_d;
    logic [NREG-1:0] clr_q, clr_d;
    logic [NREG-1:0] pre_q, pre_d;
    logic [NREG-1:0] cs_q, cs_d;
    logic            rd_q, rd_d;
    logic            bad_q, bad_d;

    logic            found;
    int unsigned     idx;
    int unsigned     win;
    op_e             w_op;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;
    logic [NREG-1:0] hit;
    logic            prot;
    logic            bad;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = '0;
        done_d  = '0;
        rdata_d = rdata_q;
        err_d   = err_q;
        reg_d_d = reg_d_q;
        we_d    = '0;
        clr_d   = '0;
        pre_d   = '0;
        cs_d    = '1;
        rd_d    = rd_q;
        bad_d   = bad_q;
        found   = 1'b0;
        idx     = 0;
        win     = 0;
        prot    = 1'b0;
        hit     = '0;

        // Winner is the first requester at or above the rr pointer, wrapping.
        for (int unsigned i = 0; i < NR; i++) begin
            idx = (rr_q + i) % NR;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        w_op    = op_e'(req_op[2*win +: 2]);
        w_addr  = req_addr[AW*win +: AW];
        w_wdata = req_wdata[DW*win +: DW];

        for (int unsigned i = 0; i < NREG; i++) begin
            hit[i] = (32'(w_addr) == i);
        end
`ifdef REG_BANK_WPROT_EN
        for (int unsigned i = 0; i < NREG; i++) begin
            if (hit[i] && wprot[i] && (w_op != OP_READ)) prot = 1'b1;
        end
`endif
        bad = ~(|hit) | prot;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    for (int unsigned i = 0; i < NR; i++) gnt_d[i] = (i == win);
                    reg_d_d = w_wdata;
                    rd_d    = (w_op == OP_READ) && !bad;
                    bad_d   = bad;
                    if (!bad) begin
                        case (w_op)
                            OP_READ:   cs_d  = ~hit;
                            OP_WRITE:  we_d  = hit;
                            OP_CLEAR:  clr_d = hit;
                            OP_PRESET: pre_d = hit;
                            default:   cs_d  = '1;
                        endcase
                    end
                    rr_d    = (win == NR - 1) ? '0 : RW'(win + 1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                done_d = gnt_q;
                err_d  = bad_q;
                if (rd_q) rdata_d = reg_q;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            reg_d_q <= '0;
            we_q    <= '0;
            clr_q   <= '0;
            pre_q   <= '0;
            cs_q    <= '1;
            rd_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            reg_d_q <= reg_d_d;
            we_q    <= we_d;
            clr_q   <= clr_d;
            pre_q   <= pre_d;
            cs_q    <= cs_d;
            rd_q    <= rd_d;
            bad_q   <= bad_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign reg_d   = reg_d_q;
    assign reg_we  = we_q;
    assign reg_clr = clr_q;
    assign reg_pre = pre_q;
    assign reg_cs  = cs_q;

endmodule

// File: tb/tb_reg_bank_access_ctrl.sv
// Bench for reg_bank_access_ctrl (AW=4 build so out-of-range addresses are reachable),
// with a behavioural register bank driving the shared Q bus.
module tb_reg_bank_access_ctrl;

    localparam int unsigned NR = 4, NREG = 8, AW = 4, DW = 8;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [2*NR-1:0]   req_op = '0;
    logic [AW*NR-1:0]  req_addr = '0;
    logic [DW*NR-1:0]  req_wdata = '0;
    logic [NR-1:0]     gnt, done;
    logic [DW-1:0]     rdata, reg_d, reg_q;
    logic              err;
    logic [NREG-1:0]   reg_we, reg_clr, reg_pre, reg_cs;
`ifdef REG_BANK_WPROT_EN
    logic [NREG-1:0]   wprot = '0;
`endif

    int ncomp = 0;
    int nfail = 0;

    reg_bank_access_ctrl #(.NR(NR), .NREG(NREG), .AW(AW), .DW(DW)) dut (
        .Clock(Clock), .Reset(Reset), .req(req), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err),
        .reg_d(reg_d), .reg_we(reg_we), .reg_clr(reg_clr), .reg_pre(reg_pre), .reg_cs(reg_cs),
`ifdef REG_BANK_WPROT_EN
        .wprot(wprot),
`endif
        .reg_q(reg_q)
    );

    always #5 Clock = ~Clock;

    logic [DW-1:0] bank [NREG];

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) bank[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (reg_clr[i])      bank[i] <= '0;
                else if (reg_pre[i]) bank[i] <= '1;
                else if (reg_we[i])  bank[i] <= reg_d;
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NREG; i++) if (!reg_cs[i]) reg_q = bank[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncomp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus-safety monitor: never two selected registers, never two strobes.
    always @(negedge Clock) begin
        if (!Reset) begin
            ncomp++;
            if ($countones(~reg_cs) > 1 ||
                ($countones(reg_we) + $countones(reg_clr) + $countones(reg_pre)) > 1) begin
                nfail++;
                $display("FAIL bus_safety: cs=%h we=%h clr=%h pre=%h", reg_cs, reg_we, reg_clr, reg_pre);
            end
        end
    end

    typedef struct {
        int unsigned r;
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [7:0]  wd;
        logic [7:0]  we, clr, pre, cs, rdata;
        logic        err;
    } vec_t;

    vec_t vt[13];

    task automatic do_access(input vec_t v, input int k);
        int  cyc;
        bit  got;
        req_op[2*v.r +: 2]    = v.op;
        req_addr[AW*v.r +: AW] = v.addr;
        req_wdata[DW*v.r +: DW] = v.wd;
        req[v.r] = 1'b1;
        cyc = 0;
        got = 0;
        while (!got && cyc < 10) begin
            @(negedge Clock);
            cyc++;
            if (gnt != '0) got = 1;
        end
        chk($sformatf("v%0d_latency", k), cyc, 1);
        chk($sformatf("v%0d_gnt", k), 32'(gnt), 32'(4'b1 << v.r));
        chk($sformatf("v%0d_we", k), 32'(reg_we), 32'(v.we));
        chk($sformatf("v%0d_clr", k), 32'(reg_clr), 32'(v.clr));
        chk($sformatf("v%0d_pre", k), 32'(reg_pre), 32'(v.pre));
        chk($sformatf("v%0d_cs", k), 32'(reg_cs), 32'(v.cs));
        chk($sformatf("v%0d_done_early", k), 32'(done), 0);
        if (v.op == 2'b01) chk($sformatf("v%0d_reg_d", k), 32'(reg_d), 32'(v.wd));
        req[v.r] = 1'b0;
        @(negedge Clock);
        chk($sformatf("v%0d_done", k), 32'(done), 32'(4'b1 << v.r));
        chk($sformatf("v%0d_err", k), 32'(err), 32'(v.err));
        chk($sformatf("v%0d_rdata", k), 32'(rdata), 32'(v.rdata));
        chk($sformatf("v%0d_gnt_off", k), 32'(gnt), 0);
        @(negedge Clock);
    endtask

    int order[5];
    int when[5];
    int ng;

    initial begin
        //        r  op     addr  wd     we     clr    pre    cs     rdata  err
        vt[0]  = '{0, 2'b01, 4'd3, 8'hA5, 8'h08, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0};
        vt[1]  = '{1, 2'b00, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF7, 8'hA5, 1'b0};
        vt[2]  = '{2, 2'b11, 4'd5, 8'h00, 8'h00, 8'h00, 8'h20, 8'hFF, 8'hA5, 1'b0};
        vt[3]  = '{2, 2'b00, 4'd5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hDF, 8'hFF, 1'b0};
        vt[4]  = '{2, 2'b10, 4'd5, 8'h00, 8'h00, 8'h20, 8'h00, 8'hFF, 8'hFF, 1'b0};
        vt[5]  = '{3, 2'b00, 4'd5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hDF, 8'h00, 1'b0};
        vt[6]  = '{1, 2'b01, 4'd0, 8'h3C, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0};
        vt[7]  = '{3, 2'b01, 4'd7, 8'hC3, 8'h80, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0};
        vt[8]  = '{0, 2'b00, 4'd7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'hC3, 1'b0};
        vt[9]  = '{1, 2'b00, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h3C, 1'b0};
        vt[10] = '{3, 2'b01, 4'd9, 8'h77, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h3C, 1'b1};
        vt[11] = '{2, 2'b00, 4'd9, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h3C, 1'b1};
        vt[12] = '{0, 2'b00, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF7, 8'hA5, 1'b0};

        repeat (2) @(negedge Clock);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_strobes", 32'({reg_we, reg_clr, reg_pre}), 0);
        chk("rst_cs", 32'(reg_cs), 32'hFF);
        chk("rst_rdata_err_d", 32'({rdata, err, reg_d}), 0);
        Reset = 1'b0;
        @(negedge Clock);

        for (int k = 0; k < 13; k++) do_access(vt[k], k);

        // Reset while a WRITE is in EXEC: strobes drop at once and no done follows.
        req_op[1:0] = 2'b01;
        req_addr[3:0] = 4'd3;
        req_wdata[7:0] = 8'h5A;
        req[0] = 1'b1;
        @(negedge Clock);
        chk("mid_gnt", 32'(gnt), 1);
        chk("mid_we_before", 32'(reg_we), 32'h08);
        req[0] = 1'b0;
        #1 Reset = 1'b1;
        #1;
        chk("mid_strobes", 32'({reg_we, reg_clr, reg_pre}), 0);
        chk("mid_cs", 32'(reg_cs), 32'hFF);
        chk("mid_gnt_off", 32'(gnt), 0);
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk($sformatf("mid_no_done%0d", i), 32'(done), 0);
        end

        // All four requesters held high: strict round-robin from pointer 0.
        req_op = '0;
        req_addr = '0;
        req = 4'b1111;
        ng = 0;
        for (int cyc = 1; cyc <= 40 && ng < 5; cyc++) begin
            @(negedge Clock);
            if (gnt != '0) begin
                for (int b = 0; b < NR; b++) if (gnt[b]) order[ng] = b;
                when[ng] = cyc;
                ng++;
            end
        end
        req = '0;
        chk("rr_count", 32'(ng), 5);
        chk("rr_first_latency", 32'(when[0]), 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 4));
            if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(when[i] - when[i-1]), 3);
        end
        repeat (4) @(negedge Clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
